fp_multiplier: RTL and testbench
================================

# fp_multiplier

Pipelined IEEE-754 single-precision (binary32) multiplier: product `p = a × b` with round-to-nearest-even. It accepts one operand pair per clock and returns the result a fixed 3 cycles later. It is the arithmetic leaf of the datapath, fed directly by upstream operand registers. It has no backpressure.

## Interface
- No parameters.
- `clk` in 1: single clock, all state rising-edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: `a`/`b` valid this cycle.
- `a` in 32: binary32 operand.
- `b` in 32: binary32 operand.
- `out_valid` out 1: `p` valid this cycle.
- `p` out 32: binary32 product.
- `flags` out 4: `{invalid, overflow, underflow, inexact}`. Present only with `FP_MUL_FLAGS_EN`.

## Operation
- Sign: `a[31] ^ b[31]`, applied to every result, including zero and inf. NaN is the exception.
- Inputs with exp = 0 (zero or subnormal) are treated as signed zero: flush-to-zero.
- Special cases, in priority order:
  - NaN input, or 0 × inf → `0x7FC00000`, invalid = 1.
  - inf × finite → signed inf.
  - zero × finite → signed zero.
- Normal path:
  - Mantissa product: `{1,ma} × {1,mb}` gives 48 bits.
  - Exponent: `ea + eb − 127` in 10-bit signed arithmetic.
  - If product bit 47 = 1: shift right 1, exp + 1.
  - Round to nearest even using guard, round and sticky bits. If rounding carries out of the mantissa, renormalize and exp + 1.
- Overflow: final exp ≥ 255 → signed inf, overflow = 1, inexact = 1.
- Underflow: final exp ≤ 0 → signed zero (no subnormal outputs), underflow = 1, inexact = 1.
- inexact = 1 whenever any discarded bit is nonzero.
- Flags are 0 for exact normal results and for exact special-case results, except invalid as stated above.

## Timing
- Three-stage pipeline. Latency: `in_valid` at edge N gives `out_valid` after edge N+3. Throughput: 1 per cycle.
  - S1: unpack, classify specials, sign/exponent sum.
  - S2: 24×24 multiply.
  - S3: normalize, round, pack.
- `in_valid` propagates through a valid shift register. `out_valid` mirrors it delayed by 3 cycles.
- While `out_valid` = 0, `p` holds its last value.
- Reset (`rst_n` low) forces all valid bits, `p` and `flags` to 0 immediately. In-flight operations are discarded.
- First accepted input is on the first rising edge after deassertion.
- Back-to-back inputs never interfere. Each result depends only on its own operands.

## Configuration
- `FP_MUL_FLAGS_EN` defined: `flags` port and its pipeline registers exist, behaving as in Operation.
- `FP_MUL_FLAGS_EN` undefined: no `flags` port and no flag logic. `p` and `out_valid` are bit-identical to the flags-enabled build.

## Structure
- Shared package `fp_pkg` holds:
  - Constants: `FP_EXP_BIAS` = 127, `FP_QNAN` = `32'h7FC00000`, `FP_POS_INF` = `32'h7F800000`.
  - Packed struct typedef `fp32_t` with fields `{sign, exp[7:0], man[22:0]}`.
  - Classification enum: zero / normal / inf / nan.
- One natural sub-module: `fp_round_pack`, the S3 normalize/round/pack logic, which is combinational.

## Test plan
- `0x45800000 × 0x45800000` → `0x4B800000` (4096² = 2²⁴), 3 cycles after `in_valid`, flags 0.
- `0xC19C0000 × 0x41080000` → `0xC325C000` (−19.5 × 8.5 = −165.75). Then `0xC1526666 × 0x00000000` → `0x80000000` on the next cycle, to check back-to-back issue.
- `0x3F800001 × 0x3F800001` → `0x3F800002`, inexact = 1 (round-to-nearest-even).
- `0x7F000000 × 0x40000000` → `0x7F800000`, overflow = 1. `0x00800000 × 0x3F000000` → `0x00000000`, underflow = 1.
- `0x7F800000 × 0x00000000` → `0x7FC00000`, invalid = 1. `0xFF800000 × 0x40000000` → `0xFF800000`.
- Assert `rst_n` low mid-stream with 3 operations in flight: `out_valid` and `p` go to 0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared binary32 definitions for the floating-point multiplier:
//                bias and special-value constants, the packed field view of a
//                binary32 word, the operand classification enum and a
//                classification helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

   localparam logic [9:0]  FP_EXP_BIAS = 10'd127;
   localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
   } fp32_t;

   typedef enum logic [1:0] {
      FP_ZERO   = 2'd0,
      FP_NORMAL = 2'd1,
      FP_INF    = 2'd2,
      FP_NAN    = 2'd3
   } fp_class_e;

   // exp == 0 covers subnormals too: they are flushed to zero.
   function automatic fp_class_e fp_classify(input fp32_t x);
      fp_class_e c;
      c = FP_NORMAL;
      if (x.exp == 8'd0) begin
         c = FP_ZERO;
      end else if (x.exp == 8'hFF) begin
         c = (x.man == 23'd0) ? FP_INF : FP_NAN;
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_pack
//  Description : Combinational normalize / round-to-nearest-even / pack stage
//                of the binary32 multiplier. Selects the precomputed special
//                result when the operands were not both normal.
//  Ports       : i_prod        48-bit mantissa product {1,ma}*{1,mb}
//                i_exp         biased exponent sum ea+eb-127 (10-bit signed)
//                i_sign        result sign
//                i_special     use i_special_res instead of the datapath
//                i_special_res packed NaN / inf / zero result
//                i_invalid     invalid flag of the special result (flags build)
//                o_p           packed binary32 result
//                o_flags       {invalid, overflow, underflow, inexact}
//                              (only with FP_MUL_FLAGS_EN)
//  Config      : FP_MUL_FLAGS_EN enables the flag inputs/outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round_pack (
   input  logic               i_sign,
   input  logic signed [9:0]  i_exp,
   input  logic        [47:0] i_prod,
   input  logic               i_special,
   input  logic        [31:0] i_special_res,
`ifdef FP_MUL_FLAGS_EN
   input  logic               i_invalid,
   output logic        [3:0]  o_flags,
`endif
   output logic        [31:0] o_p
);

   logic signed [9:0] w_exp_n;
   logic signed [9:0] w_exp_f;
   logic        [22:0] w_mant;
   logic        [23:0] w_mant_r;
   logic               w_g;
   logic               w_r;
   logic               w_s;
   logic               w_round_up;
   logic               w_ovf;
   logic               w_unf;

   always_comb begin
      // Product in [1,2): leading one at bit 46.
      w_exp_n = i_exp;
      w_mant  = i_prod[45:23];
      w_g     = i_prod[22];
      w_r     = i_prod[21];
      w_s     = |i_prod[20:0];
      // Product in [2,4): leading one at bit 47, shift right by one.
      if (i_prod[47]) begin
         w_exp_n = i_exp + 10'sd1;
         w_mant  = i_prod[46:24];
         w_g     = i_prod[23];
         w_r     = i_prod[22];
         w_s     = |i_prod[21:0];
      end

      // Above half-ulp, or exact tie with an odd lsb.
      w_round_up = w_g & (w_r | w_s | w_mant[0]);
      w_mant_r   = {1'b0, w_mant} + {23'd0, w_round_up};
      // Carry out leaves the fraction field all-zero: only the exponent moves.
      w_exp_f    = w_mant_r[23] ? (w_exp_n + 10'sd1) : w_exp_n;

      w_ovf = (w_exp_f >= 10'sd255);
      w_unf = (w_exp_f <= 10'sd0);

      o_p = {i_sign, w_exp_f[7:0], w_mant_r[22:0]};
      if (i_special) begin
         o_p = i_special_res;
      end else if (w_ovf) begin
         o_p = {i_sign, 8'hFF, 23'd0};
      end else if (w_unf) begin
         o_p = {i_sign, 31'd0};
      end
   end

`ifdef FP_MUL_FLAGS_EN
   always_comb begin
      o_flags = 4'b0000;
      if (i_special) begin
         o_flags = {i_invalid, 3'b000};
      end else if (w_ovf) begin
         o_flags = 4'b0101;
      end else if (w_unf) begin
         o_flags = 4'b0011;
      end else begin
         o_flags = {3'b000, w_g | w_r | w_s};
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/fp_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : fp_multiplier
//  Description : Three-stage pipelined binary32 multiplier, round-to-nearest-
//                even, flush-to-zero on subnormal inputs, no subnormal outputs.
//                S1 unpack/classify/exponent sum, S2 24x24 multiply,
//                S3 normalize/round/pack (fp_round_pack) into output registers.
//                One operand pair per clock, result 3 cycles later.
//  Ports       : clk       rising-edge clock
//                rst_n     asynchronous active-low reset
//                in_valid  a/b valid this cycle
//                a, b      binary32 operands
//                out_valid p valid this cycle (p holds otherwise)
//                p         binary32 product
//                flags     {invalid, overflow, underflow, inexact}
//                          (only with FP_MUL_FLAGS_EN)
//  Config      : FP_MUL_FLAGS_EN adds the flags port and its pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_multiplier
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
`ifdef FP_MUL_FLAGS_EN
   output logic [3:0]  flags,
`endif
   output logic [31:0] p
);

   // ---------------- S1: unpack, classify, exponent sum ----------------
   fp32_t             w_a;
   fp32_t             w_b;
   fp_class_e         w_ca;
   fp_class_e         w_cb;
   logic              w_sign;
   logic              w_spec;
   logic              w_inv;
   logic       [31:0] w_spec_res;
   logic signed [9:0] w_exp_sum;

   assign w_a       = a;
   assign w_b       = b;
   assign w_ca      = fp_classify(w_a);
   assign w_cb      = fp_classify(w_b);
   assign w_sign    = w_a.sign ^ w_b.sign;
   // Modulo-2^10 arithmetic; range -125..381 fits the signed interpretation.
   assign w_exp_sum = {2'b00, w_a.exp} + {2'b00, w_b.exp} - FP_EXP_BIAS;

   always_comb begin
      w_spec     = 1'b0;
      w_inv      = 1'b0;
      w_spec_res = 32'd0;
      if ((w_ca == FP_NAN) || (w_cb == FP_NAN) ||
          ((w_ca == FP_ZERO) && (w_cb == FP_INF)) ||
          ((w_ca == FP_INF) && (w_cb == FP_ZERO))) begin
         w_spec     = 1'b1;
         w_inv      = 1'b1;
         w_spec_res = FP_QNAN;
      end else if ((w_ca == FP_INF) || (w_cb == FP_INF)) begin
         w_spec     = 1'b1;
         w_spec_res = FP_POS_INF | {w_sign, 31'd0};
      end else if ((w_ca == FP_ZERO) || (w_cb == FP_ZERO)) begin
         w_spec     = 1'b1;
         w_spec_res = {w_sign, 31'd0};
      end
   end

   logic              r_s1_valid;
   logic              r_s1_sign;
   logic signed [9:0] r_s1_exp;
   logic       [23:0] r_s1_ma;
   logic       [23:0] r_s1_mb;
   logic              r_s1_spec;
   logic       [31:0] r_s1_spec_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid    <= 1'b0;
         r_s1_sign     <= 1'b0;
         r_s1_exp      <= 10'sd0;
         r_s1_ma       <= 24'd0;
         r_s1_mb       <= 24'd0;
         r_s1_spec     <= 1'b0;
         r_s1_spec_res <= 32'd0;
      end else begin
         r_s1_valid    <= in_valid;
         r_s1_sign     <= w_sign;
         r_s1_exp      <= w_exp_sum;
         r_s1_ma       <= {1'b1, w_a.man};
         r_s1_mb       <= {1'b1, w_b.man};
         r_s1_spec     <= w_spec;
         r_s1_spec_res <= w_spec_res;
      end
   end

   // ---------------- S2: 24x24 multiply ----------------
   logic              r_s2_valid;
   logic              r_s2_sign;
   logic signed [9:0] r_s2_exp;
   logic       [47:0] r_s2_prod;
   logic              r_s2_spec;
   logic       [31:0] r_s2_spec_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid    <= 1'b0;
         r_s2_sign     <= 1'b0;
         r_s2_exp      <= 10'sd0;
         r_s2_prod     <= 48'd0;
         r_s2_spec     <= 1'b0;
         r_s2_spec_res <= 32'd0;
      end else begin
         r_s2_valid    <= r_s1_valid;
         r_s2_sign     <= r_s1_sign;
         r_s2_exp      <= r_s1_exp;
         r_s2_prod     <= 48'(r_s1_ma) * 48'(r_s1_mb);
         r_s2_spec     <= r_s1_spec;
         r_s2_spec_res <= r_s1_spec_res;
      end
   end

   // ---------------- S3: normalize, round, pack ----------------
   logic [31:0] w_p;
   logic        r_out_valid;
   logic [31:0] r_p;

`ifdef FP_MUL_FLAGS_EN
   logic       r_s1_inv;
   logic       r_s2_inv;
   logic [3:0] w_flags;
   logic [3:0] r_flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_inv <= 1'b0;
         r_s2_inv <= 1'b0;
         r_flags  <= 4'd0;
      end else begin
         r_s1_inv <= w_inv;
         r_s2_inv <= r_s1_inv;
         if (r_s2_valid) begin
            r_flags <= w_flags;
         end
      end
   end

   assign flags = r_flags;
`else
   logic w_inv_unused;
   assign w_inv_unused = w_inv;
`endif

   fp_round_pack u_round_pack (
      .i_sign        (r_s2_sign),
      .i_exp         (r_s2_exp),
      .i_prod        (r_s2_prod),
      .i_special     (r_s2_spec),
      .i_special_res (r_s2_spec_res),
`ifdef FP_MUL_FLAGS_EN
      .i_invalid     (r_s2_inv),
      .o_flags       (w_flags),
`endif
      .o_p           (w_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_p         <= 32'd0;
      end else begin
         r_out_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_p <= w_p;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign p         = r_p;

endmodule
`default_nettype wire

// File: tb/tb_fp_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_multiplier
//  Description : Scoreboard bench for fp_multiplier. Expected results are
//                queued when operands are issued and compared (value, flags,
//                3-cycle latency) when out_valid is seen. Flags are checked
//                when built with FP_MUL_FLAGS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_multiplier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic [31:0] p;
`ifdef FP_MUL_FLAGS_EN
   logic [3:0]  flags;
`endif

   always #5 clk = ~clk;

   fp_multiplier dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
`ifdef FP_MUL_FLAGS_EN
      .flags     (flags),
`endif
      .p         (p)
   );

   typedef struct {
      logic [31:0] p;
      logic [3:0]  f;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
      logic [3:0]  f;   // {invalid, overflow, underflow, inexact}
   } vec_t;

   localparam int N_VEC = 17;
   vec_t vt [N_VEC] = '{
      '{32'h4580_0000, 32'h4580_0000, 32'h4B80_0000, 4'b0000}, // 4096^2
      '{32'hC19C_0000, 32'h4108_0000, 32'hC325_C000, 4'b0000}, // -19.5*8.5
      '{32'hC152_6666, 32'h0000_0000, 32'h8000_0000, 4'b0000}, // signed zero
      '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001}, // round down
      '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0101}, // overflow
      '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0011}, // underflow
      '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000}, // inf*0
      '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000}, // -inf*2
      '{32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 4'b0001}, // tie, odd -> up
      '{32'h3FC0_0000, 32'h3F80_0003, 32'h3FC0_0004, 4'b0001}, // tie, even stays
      '{32'h3FFF_FFFE, 32'h3F80_0001, 32'h4000_0000, 4'b0001}, // round carry-out
      '{32'hFFC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000}, // -NaN*1
      '{32'h0000_0001, 32'hBF80_0000, 32'h8000_0000, 4'b0000}, // subnormal flush
      '{32'hFF80_0000, 32'hFF80_0000, 32'h7F80_0000, 4'b0000}, // -inf*-inf
      '{32'h4000_0000, 32'hC040_0000, 32'hC0C0_0000, 4'b0000}, // 2*-3
      '{32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000}, // 0*-inf
      '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000}  // 1*1
   };

   exp_t        sb [$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Output monitor: pops the scoreboard on every valid result.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            chk_eq("spurious_out_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk_eq("p", p, e.p);
`ifdef FP_MUL_FLAGS_EN
            chk_eq("flags", {28'd0, flags}, {28'd0, e.f});
`endif
            chk_eq("latency", 32'(cyc), 32'(e.cyc + 3));
         end
      end
   end

   task automatic issue(input int idx);
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      a        = vt[idx].a;
      b        = vt[idx].b;
      e.p      = vt[idx].p;
      e.f      = vt[idx].f;
      e.cyc    = cyc;
      sb.push_back(e);
   endtask

   task automatic bubble(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         a        = $urandom;
         b        = $urandom;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
      chk_eq("drain_pending", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = 32'd0;
      b        = 32'd0;
      #3;
      chk_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk_eq("reset_p", p, 32'd0);
`ifdef FP_MUL_FLAGS_EN
      chk_eq("reset_flags", {28'd0, flags}, 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // First vector alone, then the rest back-to-back with occasional bubbles.
      issue(0);
      bubble(4);
      for (int i = 1; i < N_VEC; i++) begin
         issue(i);
         if (i == 7) bubble(2);
      end
      bubble(1);
      drain();

      // Output must hold its last value while idle.
      bubble(3);
      chk_eq("hold_p", p, vt[N_VEC-1].p);
      chk_eq("hold_out_valid", {31'd0, out_valid}, 32'd0);

      // Reset with three operations in flight.
      issue(1);
      issue(3);
      issue(14);
      @(posedge clk);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk_eq("midrst_p", p, 32'd0);
`ifdef FP_MUL_FLAGS_EN
      chk_eq("midrst_flags", {28'd0, flags}, 32'd0);
`endif
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bubble(6);
      chk_eq("postrst_p", p, 32'd0);

      // Recovery after reset.
      issue(3);
      bubble(1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got %0d vectors, expected completion", n_vec);
      $fatal(1);
   end

endmodule
`default_nettype wire
